// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache line refills and the data port.
// Define ARB_RR_EN for round-robin tie-breaking; the default is data-first priority.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [`XLEN-1:0]  i_addr,
  output logic              i_ready,
  output logic [`XLEN-1:0]  i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [`XLEN-1:0]  d_addr,
  input  logic [`XLEN-1:0]  d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic [`XLEN-1:0]  d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [`XLEN-1:0]  mem_addr,
  output logic [`XLEN-1:0]  mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [`XLEN-1:0]  mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  typedef enum logic {
    LG_I = 1'b0,
    LG_D = 1'b1
  } grant_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  grant_e           last_q, last_d;
  logic             pick_d;

`ifdef ARB_RR_EN
  // On a tie the requester that did not finish last wins.
  assign pick_d = d_req & (~i_req | (last_q == LG_I));
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = GNT_D;
        end else if (i_req) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        if (!i_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (mem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = LG_I;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GNT_D: begin
        if (!d_req) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = IDLE;
          last_d  = LG_D;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LG_I;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    owner     = 2'b00;
    unique case (state_q)
      GNT_I: begin
        mem_req  = i_req;
        mem_addr = i_addr;
        i_ready  = mem_ready & i_req;
        i_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
        owner    = 2'b01;
      end
      GNT_D: begin
        mem_req   = d_req;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_we ? d_wstrb : 4'h0;
        d_ready   = mem_ready & d_req;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        owner     = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// transaction-level model of ownership, burst progress and tie-breaking.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;

  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_req;
  logic [`XLEN-1:0] i_addr;
  logic             i_ready;
  logic [`XLEN-1:0] i_rdata;
  logic             d_req;
  logic             d_we;
  logic [`XLEN-1:0] d_addr;
  logic [`XLEN-1:0] d_wdata;
  logic [3:0]       d_wstrb;
  logic             d_ready;
  logic [`XLEN-1:0] d_rdata;
  logic             mem_req;
  logic             mem_we;
  logic [`XLEN-1:0] mem_addr;
  logic [`XLEN-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_ready;
  logic [`XLEN-1:0] mem_rdata;
  logic [1:0]       owner;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  int checks = 0;
  int errors = 0;

  // model: who owns memory (0 none, 1 icache, 2 data), beats done, last finisher
  int m_own = 0;
  int m_beats = 0;
  int m_last = 1;

  int i_left = 0;
  int d_left = 0;
  bit e_ir, e_dr;
  int i_seen = 0;
  int d_seen = 0;
  int prev_own = 0;
  int i_at_dgrant = -1;
  int glog[$];
  logic seen_we;
  logic [3:0] seen_strb;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_d_rand();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = $urandom & 32'hFFFF_FFFC;
    d_wdata = $urandom;
    d_wstrb = 4'($urandom_range(0, 15));
  endtask

  function automatic int tie_winner();
`ifdef ARB_RR_EN
    return (m_last == 1) ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  task automatic step();
    logic             x_req, x_we, x_ir, x_dr;
    logic [`XLEN-1:0] x_addr, x_wdata, x_ird, x_drd;
    logic [3:0]       x_strb;
    logic [1:0]       x_own;
    @(negedge clk);
    x_req = 0; x_we = 0; x_ir = 0; x_dr = 0;
    x_addr = '0; x_wdata = '0; x_ird = '0; x_drd = '0;
    x_strb = '0; x_own = 2'b00;
    if (m_own == 1) begin
      x_own = 2'b01;
      x_req = i_req;
      x_addr = i_addr;
      x_ir = i_req & mem_ready;
      x_ird = mem_rdata;
      x_drd = mem_rdata;
    end else if (m_own == 2) begin
      x_own = 2'b10;
      x_req = d_req;
      x_we = d_we;
      x_addr = d_addr;
      x_wdata = d_wdata;
      x_strb = d_we ? d_wstrb : 4'h0;
      x_dr = d_req & mem_ready;
      x_ird = mem_rdata;
      x_drd = mem_rdata;
    end
    chk("owner", owner, x_own);
    chk("mem_req", mem_req, x_req);
    chk("mem_we", mem_we, x_we);
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_wdata", mem_wdata, x_wdata);
    chk("mem_wstrb", mem_wstrb, x_strb);
    chk("i_ready", i_ready, x_ir);
    chk("d_ready", d_ready, x_dr);
    chk("i_rdata", i_rdata, x_ird);
    chk("d_rdata", d_rdata, x_drd);
    e_ir = x_ir;
    e_dr = x_dr;
    if (owner != 0 && prev_own == 0) glog.push_back(int'(owner));
    if (owner == 2 && prev_own != 2) i_at_dgrant = i_seen;
    prev_own = int'(owner);
    if (i_ready) i_seen++;
    if (d_ready) begin
      d_seen++;
      seen_we = mem_we;
      seen_strb = mem_wstrb;
    end
    @(posedge clk);
    if (!reset) begin
      m_own = 0; m_beats = 0; m_last = 1;
    end else if (m_own == 0) begin
      if (i_req && d_req) m_own = tie_winner();
      else if (d_req) m_own = 2;
      else if (i_req) m_own = 1;
    end else if (m_own == 1) begin
      if (!i_req) begin
        m_own = 0; m_beats = 0;
      end else if (mem_ready) begin
        m_beats++;
        if (m_beats == BURST) begin
          m_own = 0; m_beats = 0; m_last = 1;
        end
      end
    end else begin
      if (d_req && mem_ready) begin
        m_own = 0; m_last = 2;
      end else if (!d_req) begin
        m_own = 0;
      end
    end
    #1;
    if (e_ir) begin
      i_addr = i_addr + 4;
      i_left--;
      if (i_left == 0) i_req = 1'b0;
    end
    if (e_dr) begin
      d_left--;
      if (d_left > 0) new_d_rand();
      else begin
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
      end
    end
    mem_rdata = $urandom;
  endtask

  task automatic run_idle(input int maxc, input string tag);
    int n = 0;
    while ((i_req || d_req || m_own != 0) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    assert (n < maxc) else begin
      errors++;
      $error("FAIL %s timeout observed=%0d expected<%0d", tag, n, maxc);
    end
  endtask

  function automatic int gl(input int k);
    return (glog.size() > k) ? glog[k] : -1;
  endfunction

  int bi, bd;

  initial begin
    reset = 1'b0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 0; mem_rdata = '0;
    step();
    step();
    reset = 1'b1;
    step();

    // icache-only refill
    glog.delete();
    bi = i_seen;
    i_req = 1; i_addr = 32'h100; i_left = BURST; mem_ready = 1;
    step();
    chk("ic_req_cycle1", mem_req, 1);
    run_idle(20, "ic_burst");
    chk("ic_beats", i_seen - bi, BURST);
    chk("ic_owner", gl(0), 1);
    chk("ic_end_owner", owner, 0);

    // data write with two wait cycles
    bi = i_seen; bd = d_seen;
    d_left = 1; d_req = 1; d_we = 1; d_addr = 32'h2000;
    d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; mem_ready = 0;
    step();
    step();
    step();
    mem_ready = 1;
    run_idle(10, "d_write");
    chk("dw_pulses", d_seen - bd, 1);
    chk("dw_we", seen_we, 1);
    chk("dw_strb", seen_strb, 4'hF);
    chk("dw_no_iready", i_seen - bi, 0);

    // ties right after reset: the second tie arises when data re-requests
    reset = 0;
    step();
    reset = 1;
    glog.delete();
    i_req = 1; i_addr = 32'h300; i_left = BURST;
    d_left = 2; d_req = 1; d_we = 0; d_addr = 32'h400;
    mem_ready = 1;
    run_idle(40, "tie");
    chk("tie_count", glog.size(), 3);
`ifdef ARB_RR_EN
    chk("tie_g0", gl(0), 2);
    chk("tie_g1", gl(1), 1);
    chk("tie_g2", gl(2), 2);
`else
    chk("tie_g0", gl(0), 2);
    chk("tie_g1", gl(1), 2);
    chk("tie_g2", gl(2), 1);
`endif

    // burst lock: data request after the first beat waits for the burst
    glog.delete();
    bi = i_seen;
    i_req = 1; i_addr = 32'h500; i_left = BURST; mem_ready = 1;
    step();
    step();
    d_left = 1; d_req = 1; d_we = 0; d_addr = 32'h600;
    run_idle(30, "lock");
    chk("lock_beats", i_at_dgrant - bi, BURST);
    chk("lock_g0", gl(0), 1);
    chk("lock_g1", gl(1), 2);

    // abort after two beats
    bi = i_seen;
    i_req = 1; i_addr = 32'h700; i_left = BURST; mem_ready = 1;
    step();
    step();
    step();
    i_req = 0; i_left = 0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    step();
    chk("abort_idle", owner, 0);
    chk("abort_beats", i_seen - bi, 2);

    // asynchronous reset in the middle of a data transfer
    d_left = 1; d_req = 1; d_we = 1; d_addr = 32'h800;
    d_wdata = 32'h1234_5678; d_wstrb = 4'h3; mem_ready = 0;
    step();
    step();
    chk("rst_pre_owner", owner, 2);
    reset = 0;
    #1;
    chk("rst_owner", owner, 0);
    chk("rst_mem_req", mem_req, 0);
    m_own = 0; m_beats = 0; m_last = 1;
    step();
    step();
    reset = 1;
    glog.delete();
    bd = d_seen;
    mem_ready = 1;
    run_idle(10, "rst_rearb");
    chk("rst_regrant", gl(0), 2);
    chk("rst_done", d_seen - bd, 1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      mem_ready = ($urandom_range(0, 2) != 0);
      if (!i_req && $urandom_range(0, 4) == 0) begin
        i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC; i_left = BURST;
      end else if (i_req && m_own == 1 && $urandom_range(0, 19) == 0) begin
        i_req = 0; i_left = 0;
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_left = 1;
        new_d_rand();
      end
      step();
    end
    mem_ready = 1;
    run_idle(200, "rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
